// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. It accepts one request, holds dbusy
// through READ_LAT or WRITE_LAT wait states, then completes with a
// one-cycle active-low dready_n strobe.
// Latency: accepted in cycle 0, dbusy in cycles 1..L, and dready_n=0 in cycle L+1.
// Requests are accepted only in IDLE, and dreq is ignored while a transaction
// is in flight. The minimum spacing between acceptances is L+2 cycles.
// Ports: clk/rst (sync, active-high); dreq/dwrite/daddr/dsize/input_ddata request;
//        output_ddata (zero except in read DONE), dready_n, dbusy, dmisalign.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 2,
  parameter int WRITE_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  input  logic [31:0] input_ddata,
  output logic [31:0] output_ddata,
  output logic        dready_n,
  output logic        dbusy,
  output logic        dmisalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] RLAT = 4'(READ_LAT);
  localparam logic [3:0] WLAT = 4'(WRITE_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          l_write;
  logic [AW+1:0] l_addr;
  logic [1:0]    l_size;
  logic [31:0]   l_data;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the storage depth are deliberately ignored, so
  // addresses wrap modulo the depth.
  logic unused_addr;
  assign unused_addr = ^daddr[31:AW+2];

  // Transaction view: when L=0, the request completes on the same edge that
  // accepts it. In that case, the live inputs drive the commit rather than the
  // latched copy.
  logic          in_idle;
  logic          c_write;
  logic [AW+1:0] c_addr;
  logic [1:0]    c_size;
  logic [31:0]   c_data;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [3:0]    acc_lat;
  logic          going_done;

  assign in_idle = (state == IDLE);
  assign c_write = in_idle ? dwrite             : l_write;
  assign c_addr  = in_idle ? daddr[AW+1:0]      : l_addr;
  assign c_size  = in_idle ? dsize              : l_size;
  assign c_data  = in_idle ? input_ddata        : l_data;
  assign lane    = c_addr[1:0];
  assign idx     = c_addr[AW+1:2];
  assign acc_lat = dwrite ? WLAT : RLAT;

  // Reset wins over both completion paths. This discards an in-flight write.
  assign going_done = !rst && ((in_idle && dreq && (acc_lat == 4'd0)) ||
                               ((state == WAIT) && (cnt == 4'd1)));

  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rmask;
  logic [31:0] rd_word;
  logic [31:0] rd_val;
  logic [31:0] finish_rdata;

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wdata_sh = 32'h0;
    rmask    = 32'h0;
    case (c_size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_sh = {24'h0, c_data[7:0]} << {lane, 3'b000};
        rmask    = 32'h0000_00FF;
      end
      2'b01: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh = lane[1] ? {c_data[15:0], 16'h0} : {16'h0, c_data[15:0]};
        rmask    = 32'h0000_FFFF;
      end
      default: begin
        misalign = (lane != 2'b00);
        be       = 4'b1111;
        wdata_sh = c_data;
        rmask    = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign rd_word      = mem[idx];
  assign rd_val       = (rd_word >> {lane, 3'b000}) & rmask;
  assign finish_rdata = (!c_write && !misalign) ? rd_val : 32'h0;

  // Storage is not reset. Only the enabled byte lanes of an aligned write
  // change, and they change on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (going_done && c_write && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      dready_n     <= 1'b1;
      dbusy        <= 1'b0;
      output_ddata <= 32'h0;
      dmisalign    <= 1'b0;
      l_write      <= 1'b0;
      l_addr       <= '0;
      l_size       <= 2'b00;
      l_data       <= 32'h0;
    end else begin
      dready_n     <= 1'b1;
      dmisalign    <= 1'b0;
      output_ddata <= 32'h0;

      if (in_idle && dreq) begin
        l_write <= dwrite;
        l_addr  <= daddr[AW+1:0];
        l_size  <= dsize;
        l_data  <= input_ddata;
      end

      if (going_done) begin
        state        <= DONE;
        cnt          <= 4'd0;
        dbusy        <= 1'b0;
        dready_n     <= 1'b0;
        dmisalign    <= misalign;
        output_ddata <= finish_rdata;
      end else begin
        case (state)
          IDLE: begin
            if (dreq) begin
              state <= WAIT;
              cnt   <= acc_lat;
              dbusy <= 1'b1;
            end
          end
          WAIT:    cnt   <= cnt - 4'd1;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (READ_LAT=2, WRITE_LAT=1).
// Covers handshake timing, byte/half/word merging, misalignment, back-to-back aliasing, and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        dreq;
  logic        dwrite;
  logic [31:0] daddr;
  logic [1:0]  dsize;
  logic [31:0] input_ddata;
  logic [31:0] output_ddata;
  logic        dready_n;
  logic        dbusy;
  logic        dmisalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .READ_LAT(2), .WRITE_LAT(1)) dut (
    .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .input_ddata(input_ddata), .output_ddata(output_ddata),
    .dready_n(dready_n), .dbusy(dbusy), .dmisalign(dmisalign)
  );

  // Issue one request and observe it up to its DONE cycle. done_cyc is the
  // cycle number after acceptance, or 0 if the request never completed.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] d, output logic [31:0] rd, output logic mis,
                     output int busy, output int done_cyc);
    rd = 32'h0; mis = 1'b0; busy = 0; done_cyc = 0;
    @(posedge clk); #1;
    dreq = 1'b1; dwrite = wr; daddr = a; dsize = sz; input_ddata = d;
    @(posedge clk); #1;
    dreq = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (dbusy) busy++;
      if (!dready_n) begin
        done_cyc = n; rd = output_ddata; mis = dmisalign;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dreq = 1'b0; dwrite = 1'b0; daddr = 32'h0; dsize = 2'b00; input_ddata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dready_n !== 1'b1) begin errors++; $display("FAIL reset_dready_n: got %b want 1", dready_n); end
    checks++; if (dbusy !== 1'b0) begin errors++; $display("FAIL reset_dbusy: got %b want 0", dbusy); end
    checks++; if (output_ddata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", output_ddata); end
    checks++; if (dmisalign !== 1'b0) begin errors++; $display("FAIL reset_dmisalign: got %b want 0", dmisalign); end
    rst = 1'b0;
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd; logic mis; int busy, dc;
    txn(1'b1, 32'h100, 2'b10, 32'hDEADBEEF, rd, mis, busy, dc);
    checks++; if (busy !== 1) begin errors++; $display("FAIL wr_busy_cycles: got %0d want 1", busy); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL wr_done_cycle: got %0d want 2", dc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata_zero: got %h want 00000000", rd); end
    txn(1'b0, 32'h100, 2'b10, 32'h0, rd, mis, busy, dc);
    checks++; if (dc !== 3) begin errors++; $display("FAIL rd_done_cycle: got %0d want 3", dc); end
    checks++; if (busy !== 2) begin errors++; $display("FAIL rd_busy_cycles: got %0d want 2", busy); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rt_data: got %h want deadbeef", rd); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL word_rt_mis: got %b want 0", mis); end
    @(negedge clk);
    checks++; if (output_ddata !== 32'h0) begin errors++; $display("FAIL rdata_after_done: got %h want 00000000", output_ddata); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd; logic mis; int busy, dc;
    txn(1'b1, 32'h200, 2'b10, 32'h11223344, rd, mis, busy, dc);
    txn(1'b1, 32'h202, 2'b00, 32'hFFFFFFAA, rd, mis, busy, dc);
    txn(1'b0, 32'h200, 2'b10, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL byte_merge_word: got %h want 11aa3344", rd); end
    txn(1'b0, 32'h203, 2'b00, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL byte_read_lane3: got %h want 00000011", rd); end
    txn(1'b0, 32'h200, 2'b00, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL byte_read_lane0: got %h want 00000044", rd); end
  endtask

  task automatic test_half_access();
    logic [31:0] rd; logic mis; int busy, dc;
    txn(1'b1, 32'h308, 2'b10, 32'h0, rd, mis, busy, dc);
    txn(1'b1, 32'h30A, 2'b01, 32'h1234BEEF, rd, mis, busy, dc);
    txn(1'b0, 32'h308, 2'b10, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL half_word_view: got %h want beef0000", rd); end
    txn(1'b0, 32'h30A, 2'b01, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL half_read: got %h want 0000beef", rd); end
    txn(1'b0, 32'h308, 2'b11, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL size11_as_word: got %h want beef0000", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic mis; int busy, dc;
    txn(1'b1, 32'h400, 2'b10, 32'hCAFEF00D, rd, mis, busy, dc);
    txn(1'b1, 32'h401, 2'b10, 32'h12345678, rd, mis, busy, dc);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_word_write_flag: got %b want 1", mis); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL mis_write_done_cycle: got %0d want 2", dc); end
    txn(1'b0, 32'h403, 2'b01, 32'h0, rd, mis, busy, dc);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_half_read_flag: got %b want 1", mis); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_read_data: got %h want 00000000", rd); end
    txn(1'b0, 32'h400, 2'b10, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_mem_unchanged: got %h want cafef00d", rd); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL aligned_mis_clear: got %b want 0", mis); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic mis; int busy, dc;
    int ndone; int busy_cnt; int done_at [3];
    logic [31:0] data_at [3];
    txn(1'b1, 32'h0, 2'b10, 32'hA5A50001, rd, mis, busy, dc);
    ndone = 0; busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin done_at[i] = 0; data_at[i] = 32'h0; end
    @(posedge clk); #1;
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h1000; dsize = 2'b10;
    @(posedge clk);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (dbusy) busy_cnt++;
      if (!dready_n && ndone < 3) begin done_at[ndone] = n; data_at[ndone] = output_ddata; ndone++; end
    end
    dreq = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
    checks++; if (done_at[0] !== 3 || done_at[1] !== 7 || done_at[2] !== 11) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d,%0d,%0d want 3,7,11", done_at[0], done_at[1], done_at[2]); end
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 6", busy_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_at[i] !== 32'hA5A50001) begin errors++; $display("FAIL b2b_alias_data%0d: got %h want a5a50001", i, data_at[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic mis; int busy, dc;
    int strobes;
    txn(1'b1, 32'h500, 2'b10, 32'h0BADF00D, rd, mis, busy, dc);
    @(posedge clk); #1;
    dreq = 1'b1; dwrite = 1'b1; daddr = 32'h500; dsize = 2'b10; input_ddata = 32'h12345678;
    @(posedge clk); #1;
    dreq = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (dbusy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", dbusy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dbusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_drop: got %b want 0", dbusy); end
    checks++; if (dready_n !== 1'b1) begin errors++; $display("FAIL rstmid_no_strobe: got %b want 1", dready_n); end
    txn(1'b0, 32'h500, 2'b10, 32'h0, rd, mis, busy, dc);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_write_discarded: got %h want 0badf00d", rd); end
    // A request asserted together with reset is not accepted.
    @(posedge clk); #1;
    rst = 1'b1; dreq = 1'b1; dwrite = 1'b0; daddr = 32'h500;
    @(posedge clk); #1;
    rst = 1'b0; dreq = 1'b0;
    strobes = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (dbusy || !dready_n) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL rst_dreq_same_cycle: got %0d active cycles want 0", strobes); end
  endtask

  initial begin
    test_reset();
    test_word_round_trip();
    test_byte_merge();
    test_half_access();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
